// File: rtl/ahbl_apb_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge.
//   - bridge FSM state encoding
//   - AHB HTRANS and HRESP codes
//   - width of the APB slot index carried in HADDR
package ahbl_apb_pkg;

    localparam int SLOT_IDX_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } bridge_state_e;

    // NONSEQ and SEQ start a real transfer; IDLE and BUSY get a zero-wait OKAY.
    function automatic logic trans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/apb_slot_mux.sv
// Combinational APB slot steering for the bridge.
// Ports:
//   slot        - latched 4-bit slot index
//   sel_en      - bridge is in SETUP/ACCESS with a valid slot
//   prdata      - per-slot read data, slot k at [32k+31:32k]
//   pready      - per-slot ready
//   pslverr     - per-slot error
//   psel        - one-hot slot select (all-zero when disabled or slot out of range)
//   prdata_sel  - read data of the selected slot
//   pready_sel  - ready of the selected slot (0 when slot out of range)
//   pslverr_sel - error of the selected slot (0 when slot out of range)
module apb_slot_mux
    import ahbl_apb_pkg::*;
#(
    parameter int APB_SLOTS = 16
) (
    input  logic [SLOT_IDX_W-1:0]   slot,
    input  logic                    sel_en,
    input  logic [32*APB_SLOTS-1:0] prdata,
    input  logic [APB_SLOTS-1:0]    pready,
    input  logic [APB_SLOTS-1:0]    pslverr,
    output logic [APB_SLOTS-1:0]    psel,
    output logic [31:0]             prdata_sel,
    output logic                    pready_sel,
    output logic                    pslverr_sel
);

    // Each slot compares against its own index, so at most one PSEL bit can
    // ever be set.
    always_comb begin
        psel        = '0;
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        for (int k = 0; k < APB_SLOTS; k++) begin
            if (slot == SLOT_IDX_W'(k)) begin
                psel[k]     = sel_en;
                prdata_sel  = prdata[32*k +: 32];
                pready_sel  = pready[k];
                pslverr_sel = pslverr[k];
            end
        end
    end

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to multi-slot APB master bridge.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | ready, OKAY; accepts a new transfer (also the completion cycle)
//   ST_SETUP  | APB setup phase, PSEL high, PENABLE low, PWDATA from HWDATA
//   ST_ACCESS | APB access phase, PENABLE high, waits for PREADY or timeout
//   ST_ERR1   | first ERROR cycle, HREADYOUT low
//   ST_ERR2   | second ERROR cycle, HREADYOUT high; accepts a new transfer
//
// Ports: HCLK/HRESETN clock and async active-low reset; AHB-Lite slave side
// (HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADYIN -> HREADYOUT, HRDATA,
// HRESP); APB master side (PSEL one-hot per slot, PADDR, PWRITE, PENABLE,
// PWDATA -> PRDATA, PREADY, PSLVERR packed per slot).
// TPD is an output delay for behavioural models only; this RTL is zero-delay.
module ahbl_apb_bridge
    import ahbl_apb_pkg::*;
#(
    parameter int APB_SLOTS = 16,
    parameter int SLOT_LSB  = 8,
    parameter int TIMEOUT   = 256,
    parameter int TPD       = 1
) (
    input  logic                    HCLK,
    input  logic                    HRESETN,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic                    HWRITE,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADYIN,
    output logic                    HREADYOUT,
    output logic [31:0]             HRDATA,
    output logic                    HRESP,
    output logic [APB_SLOTS-1:0]    PSEL,
    output logic [31:0]             PADDR,
    output logic                    PWRITE,
    output logic                    PENABLE,
    output logic [31:0]             PWDATA,
    input  logic [32*APB_SLOTS-1:0] PRDATA,
    input  logic [APB_SLOTS-1:0]    PREADY,
    input  logic [APB_SLOTS-1:0]    PSLVERR
);

    if (APB_SLOTS < 1 || APB_SLOTS > 16 || TIMEOUT < 0 || TPD < 0) begin : g_bad_param
        $error("ahbl_apb_bridge: parameter out of range");
    end

    localparam int TCNT_W = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;
    localparam logic [TCNT_W-1:0] TCNT_LAST = (TIMEOUT > 0) ? TCNT_W'(TIMEOUT - 1) : '0;

    bridge_state_e           state;
    logic [31:0]             addr_q;
    logic [31:0]             pwdata_q;
    logic [31:0]             hrdata_q;
    logic                    write_q;
    logic                    psel_en_q;
    logic                    penable_q;
    logic                    hreadyout_q;
    logic                    hresp_q;
    logic [SLOT_IDX_W-1:0]   slot_q;
    logic [TCNT_W-1:0]       tcnt_q;

    logic [SLOT_IDX_W-1:0]   slot_in;
    logic                    slot_in_ok;
    logic                    accept;
    logic                    timeout_hit;
    logic [31:0]             prdata_sel;
    logic                    pready_sel;
    logic                    pslverr_sel;
    logic                    unused_hsize;

    assign unused_hsize = ^HSIZE;

    assign slot_in     = HADDR[SLOT_LSB +: SLOT_IDX_W];
    assign slot_in_ok  = ({{(32-SLOT_IDX_W){1'b0}}, slot_in} < 32'(APB_SLOTS));
    assign accept      = HSEL && HREADYIN && trans_active(HTRANS);
    assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TCNT_LAST);

    apb_slot_mux #(
        .APB_SLOTS (APB_SLOTS)
    ) u_slot_mux (
        .slot        (slot_q),
        .sel_en      (psel_en_q),
        .prdata      (PRDATA),
        .pready      (PREADY),
        .pslverr     (PSLVERR),
        .psel        (PSEL),
        .prdata_sel  (prdata_sel),
        .pready_sel  (pready_sel),
        .pslverr_sel (pslverr_sel)
    );

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            write_q     <= 1'b0;
            psel_en_q   <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            slot_q      <= '0;
            tcnt_q      <= '0;
        end else begin
            case (state)
                // ERR2 already shows HREADYOUT=1, so the master's next
                // address phase lands here and is handled like IDLE.
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        addr_q      <= HADDR;
                        write_q     <= HWRITE;
                        slot_q      <= slot_in;
                        hreadyout_q <= 1'b0;
                        if (slot_in_ok) begin
                            state     <= ST_SETUP;
                            psel_en_q <= 1'b1;
                            hresp_q   <= HRESP_OKAY;
                        end else begin
                            state     <= ST_ERR1;
                            hresp_q   <= HRESP_ERROR;
                        end
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_SETUP: begin
                    pwdata_q  <= HWDATA;
                    penable_q <= 1'b1;
                    tcnt_q    <= '0;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_sel) begin
                        psel_en_q <= 1'b0;
                        penable_q <= 1'b0;
                        if (pslverr_sel) begin
                            state   <= ST_ERR1;
                            hresp_q <= HRESP_ERROR;
                        end else begin
                            state       <= ST_IDLE;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                            if (!write_q) begin
                                hrdata_q <= prdata_sel;
                            end
                        end
                    end else if (timeout_hit) begin
                        psel_en_q <= 1'b0;
                        penable_q <= 1'b0;
                        state     <= ST_ERR1;
                        hresp_q   <= HRESP_ERROR;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    psel_en_q   <= 1'b0;
                    penable_q   <= 1'b0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // HWDATA belongs to the AHB data phase, which coincides with SETUP, so it
    // is passed straight through there and held from the register afterwards.
    assign PWDATA    = (state == ST_SETUP) ? HWDATA : pwdata_q;
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PENABLE   = penable_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Self-checking bench for ahbl_apb_bridge (4 slots, 8-cycle timeout).
// Each AHB transfer is turned into an expected per-cycle timeline: setup,
// wait cycles, then OKAY completion or the two-cycle ERROR, and every cycle
// is compared with that timeline. Outputs are sampled 1 ns after the edge.
module tb_ahbl_apb_bridge;
    import ahbl_apb_pkg::*;

    localparam int SLOTS = 4;
    localparam int TMO   = 8;

    logic                HCLK = 1'b0;
    logic                HRESETN;
    logic                HSEL;
    logic [31:0]         HADDR;
    logic                HWRITE;
    logic [1:0]          HTRANS;
    logic [2:0]          HSIZE;
    logic [31:0]         HWDATA;
    logic                HREADYIN;
    logic                HREADYOUT;
    logic [31:0]         HRDATA;
    logic                HRESP;
    logic [SLOTS-1:0]    PSEL;
    logic [31:0]         PADDR;
    logic                PWRITE;
    logic                PENABLE;
    logic [31:0]         PWDATA;
    logic [32*SLOTS-1:0] PRDATA;
    logic [SLOTS-1:0]    PREADY;
    logic [SLOTS-1:0]    PSLVERR;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] hrdata_m;

    always #5 HCLK = ~HCLK;

    ahbl_apb_bridge #(
        .APB_SLOTS (SLOTS),
        .SLOT_LSB  (8),
        .TIMEOUT   (TMO),
        .TPD       (1)
    ) dut (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .PSEL      (PSEL),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_psel"},   32'(PSEL),      32'h0);
        check_val({tag, "_pen"},    32'(PENABLE),   32'h0);
        check_val({tag, "_pwrite"}, 32'(PWRITE),    32'h0);
        check_val({tag, "_paddr"},  PADDR,          32'h0);
        check_val({tag, "_pwdata"}, PWDATA,         32'h0);
        check_val({tag, "_hrdata"}, HRDATA,         32'h0);
        check_val({tag, "_hready"}, 32'(HREADYOUT), 32'h1);
        check_val({tag, "_hresp"},  32'(HRESP),     32'h0);
    endtask

    task automatic randomize_slaves();
        for (int k = 0; k < SLOTS; k++) PRDATA[32*k +: 32] = $urandom;
        PREADY  = SLOTS'($urandom);
        PSLVERR = SLOTS'($urandom);
    endtask

    // One cycle in which no transfer may start; zero-wait OKAY expected.
    task automatic idle_cycle();
        case ($urandom_range(0, 3))
            0:       begin HSEL = 1'b0; HTRANS = HTRANS_NONSEQ; HREADYIN = 1'b1; end
            1:       begin HSEL = 1'b1; HTRANS = HTRANS_IDLE;   HREADYIN = 1'b1; end
            2:       begin HSEL = 1'b1; HTRANS = HTRANS_BUSY;   HREADYIN = 1'b1; end
            default: begin HSEL = 1'b1; HTRANS = HTRANS_SEQ;    HREADYIN = 1'b0; end
        endcase
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
        randomize_slaves();
        step();
        check_val("idle_hready", 32'(HREADYOUT), 32'h1);
        check_val("idle_hresp",  32'(HRESP),     32'h0);
        check_val("idle_psel",   32'(PSEL),      32'h0);
        check_val("idle_pen",    32'(PENABLE),   32'h0);
        check_val("idle_hrdata", HRDATA,         hrdata_m);
    endtask

    // Called in a cycle where the bridge shows HREADYOUT=1; drives the address
    // phase there and returns in the last cycle of the response (HREADYOUT=1),
    // where the next transfer may start. delay = PREADY-low ACCESS cycles;
    // rst_at >= 0 pulses reset in that ACCESS cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay, input logic err, input int rst_at);
        int         s;
        logic [3:0] psel_exp;
        s = int'(addr[11:8]);
        randomize_slaves();
        if (s < SLOTS) PRDATA[32*s +: 32] = rdata;
        HSEL     = 1'b1;
        HTRANS   = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
        HADDR    = addr;
        HWRITE   = wr;
        HREADYIN = 1'b1;
        HWDATA   = $urandom;
        step();
        HSEL     = 1'($urandom);
        HTRANS   = 2'($urandom);
        HREADYIN = 1'b0;
        HADDR    = $urandom;
        HWRITE   = 1'($urandom);
        HWDATA   = wdata;
        if (s >= SLOTS) begin
            check_val("oor_err1_hready", 32'(HREADYOUT), 32'h0);
            check_val("oor_err1_hresp",  32'(HRESP),     32'h1);
            check_val("oor_err1_psel",   32'(PSEL),      32'h0);
            step();
            check_val("oor_err2_hready", 32'(HREADYOUT), 32'h1);
            check_val("oor_err2_hresp",  32'(HRESP),     32'h1);
            check_val("oor_err2_psel",   32'(PSEL),      32'h0);
            check_val("oor_err2_hrdata", HRDATA,         hrdata_m);
            return;
        end
        psel_exp = 4'b0001 << s;
        check_val("setup_psel",   32'(PSEL),      32'(psel_exp));
        check_val("setup_pen",    32'(PENABLE),   32'h0);
        check_val("setup_paddr",  PADDR,          addr);
        check_val("setup_pwrite", 32'(PWRITE),    32'(wr));
        check_val("setup_hready", 32'(HREADYOUT), 32'h0);
        #1;
        check_val("setup_pwdata", PWDATA, wdata);
        for (int i = 0; ; i++) begin
            step();
            if (i == rst_at) begin
                HRESETN = 1'b0;
                #1;
                hrdata_m = 32'h0;
                check_reset("rst_mid");
                step();
                HRESETN = 1'b1;
                return;
            end
            check_val("acc_psel",   32'(PSEL),      32'(psel_exp));
            check_val("acc_pen",    32'(PENABLE),   32'h1);
            check_val("acc_paddr",  PADDR,          addr);
            check_val("acc_pwrite", 32'(PWRITE),    32'(wr));
            check_val("acc_pwdata", PWDATA,         wdata);
            check_val("acc_hready", 32'(HREADYOUT), 32'h0);
            HWDATA  = $urandom;
            HSEL    = 1'($urandom);
            HTRANS  = 2'($urandom);
            PREADY  = SLOTS'($urandom);
            PSLVERR = SLOTS'($urandom);
            PREADY[s]  = (i == delay);
            PSLVERR[s] = (i == delay) ? err : 1'($urandom);
            if (i == delay || i == TMO - 1) break;
        end
        step();
        check_val("end_psel", 32'(PSEL),    32'h0);
        check_val("end_pen",  32'(PENABLE), 32'h0);
        if (delay >= TMO || err) begin
            check_val("err1_hready", 32'(HREADYOUT), 32'h0);
            check_val("err1_hresp",  32'(HRESP),     32'h1);
            step();
            check_val("err2_hready", 32'(HREADYOUT), 32'h1);
            check_val("err2_hresp",  32'(HRESP),     32'h1);
            check_val("err2_psel",   32'(PSEL),      32'h0);
            check_val("err2_hrdata", HRDATA,         hrdata_m);
        end else begin
            if (!wr) hrdata_m = rdata;
            check_val("ok_hready", 32'(HREADYOUT), 32'h1);
            check_val("ok_hresp",  32'(HRESP),     32'h0);
            check_val("ok_hrdata", HRDATA,         hrdata_m);
        end
    endtask

    initial begin
        HRESETN  = 1'b0;
        HSEL     = 1'b0;
        HADDR    = 32'h0;
        HWRITE   = 1'b0;
        HTRANS   = HTRANS_IDLE;
        HSIZE    = 3'b010;
        HWDATA   = 32'h0;
        HREADYIN = 1'b1;
        PRDATA   = '0;
        PREADY   = '0;
        PSLVERR  = '0;
        hrdata_m = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        check_reset("por");
        HRESETN = 1'b1;
        repeat (3) idle_cycle();

        // write slot 1, zero wait
        xfer(32'h0000_0104, 1'b1, 32'hA5A5_5A5A, 32'hDEAD_0001, 0, 1'b0, -1);
        idle_cycle();
        // read slot 3 with four wait cycles
        xfer(32'h0000_0304, 1'b0, 32'h0, 32'h1234_5678, 4, 1'b0, -1);
        // slave error on slot 2, HRDATA must keep the previous read
        xfer(32'h0000_0200, 1'b0, 32'h0, 32'hBAD0_BAD0, 2, 1'b1, -1);
        // slot 5 does not exist with 4 slots
        xfer(32'h0000_0500, 1'b1, 32'h1111_2222, 32'h0, 0, 1'b0, -1);
        idle_cycle();
        // PREADY stuck low -> timeout, then ready on the last allowed cycle
        xfer(32'h0000_0100, 1'b0, 32'h0, 32'h5555_AAAA, 40, 1'b0, -1);
        xfer(32'h0000_0100, 1'b0, 32'h0, 32'h7777_8888, TMO - 1, 1'b0, -1);
        // back-to-back write then read
        xfer(32'h0000_0008, 1'b1, 32'hCAFE_F00D, 32'h0BAD_0BAD, 0, 1'b0, -1);
        xfer(32'h0000_030C, 1'b0, 32'h0, 32'h0246_8ACE, 1, 1'b0, -1);
        // reset in ACCESS, then normal traffic
        xfer(32'h0000_0110, 1'b0, 32'h0, 32'h9999_9999, 5, 1'b0, 2);
        xfer(32'h0000_0210, 1'b1, 32'h1357_9BDF, 32'hFFFF_0000, 1, 1'b0, -1);
        xfer(32'h0000_0014, 1'b0, 32'h0, 32'h4242_4242, 0, 1'b0, -1);
        idle_cycle();

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            int          s;
            int          d;
            int          r;
            s = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 15));
            a = $urandom;
            a[11:8] = 4'(s);
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 7));
            r = -1;
            if (d >= 2 && $urandom_range(0, 29) == 0) r = int'($urandom_range(0, 1));
            xfer(a, 1'($urandom), $urandom, $urandom, d, ($urandom_range(0, 4) == 0), r);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
